// File: rtl/alu_pkg.sv
// Shared ALU definitions: function select codes used by the RTL and the bench.
package alu_pkg;

  typedef enum logic [2:0] {
    F_AND    = 3'b000,
    F_OR     = 3'b001,
    F_ADD    = 3'b010,
    F_UNUSED = 3'b011,
    F_AND_N  = 3'b100,
    F_OR_N   = 3'b101,
    F_SUB    = 3'b110,
    F_SLT    = 3'b111
  } alu_func_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational N-bit adder with optional B inversion and matching carry-in.
module alu_addsub #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         ovf
);

  logic [N-1:0] bb;
  logic [N:0]   s;

  assign bb = sub ? ~b : b;
  assign s  = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, sub};

  assign sum   = s[N-1:0];
  assign carry = s[N];
  // Overflow judged against the effective operand, so it covers both add and subtract.
  assign ovf   = (a[N-1] == bb[N-1]) && (s[N-1] != a[N-1]);

endmodule

// File: rtl/alu.sv
// Registered ALU: logic, add, subtract and set-less-than with carry and overflow flags.
module alu
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [2:0]   i_f,
  output logic [N-1:0] o_y,
  output logic         o_c,
  output logic         o_ovf
);

  logic [N-1:0] sum;
  logic         carry;
  logic         as_ovf;
  logic [N-1:0] y_nxt;
  logic         c_nxt;
  logic         ovf_nxt;

  alu_addsub #(.N(N)) u_addsub (
    .a     (i_a),
    .b     (i_b),
    .sub   (i_f[2]),
    .sum   (sum),
    .carry (carry),
    .ovf   (as_ovf)
  );

  always_comb begin
    y_nxt   = '0;
    c_nxt   = 1'b0;
    ovf_nxt = 1'b0;
    case (alu_func_e'(i_f))
      F_AND:   y_nxt = i_a & i_b;
      F_OR:    y_nxt = i_a | i_b;
      F_ADD: begin
        y_nxt   = sum;
        c_nxt   = carry;
        ovf_nxt = as_ovf;
      end
      F_AND_N: y_nxt = i_a & ~i_b;
      F_OR_N:  y_nxt = i_a | ~i_b;
      F_SUB: begin
        y_nxt   = sum;
        c_nxt   = carry;
        ovf_nxt = as_ovf;
      end
      // Signed less-than: sign of the difference corrected by overflow.
      F_SLT: begin
        y_nxt = {{(N-1){1'b0}}, sum[N-1] ^ as_ovf};
        c_nxt = carry;
      end
      default: begin
        y_nxt   = '0;
        c_nxt   = 1'b0;
        ovf_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_y   <= '0;
      o_c   <= 1'b0;
      o_ovf <= 1'b0;
    end else begin
      o_y   <= y_nxt;
      o_c   <= c_nxt;
      o_ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, random sweep, reset corner cases.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rstn;
  logic [31:0] a, b;
  logic [2:0]  f;
  logic [31:0] y;
  logic        c, ovf;

  int checks = 0;
  int errors = 0;

  alu #(.N(32)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_a    (a),
    .i_b    (b),
    .i_f    (f),
    .o_y    (y),
    .o_c    (c),
    .o_ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    alu_func_e   fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        c;
    logic        ovf;
  } vec_t;

  // Reference model from integer arithmetic on the operand values.
  function automatic void model(input logic [2:0] fn, input logic [31:0] ra, input logic [31:0] rb,
                                output logic [31:0] ry, output logic rc, output logic rovf);
    longint ua, ub, sa, sb, r;
    ua = longint'({32'd0, ra});
    ub = longint'({32'd0, rb});
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    ry = '0; rc = 1'b0; rovf = 1'b0;
    case (fn)
      3'b000: ry = ra & rb;
      3'b001: ry = ra | rb;
      3'b010: begin
        r = ua + ub;
        ry = r[31:0];
        rc = (r >= 64'sd4294967296);
        r = sa + sb;
        rovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'b100: ry = ra & ~rb;
      3'b101: ry = ra | ~rb;
      3'b110: begin
        r = ua - ub;
        ry = r[31:0];
        rc = (ua >= ub);
        r = sa - sb;
        rovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'b111: begin
        ry = (sa < sb) ? 32'd1 : 32'd0;
        rc = (ua >= ub);
      end
      default: ;
    endcase
  endfunction

  task automatic compare(input string name, input logic [31:0] ey, input logic ec, input logic eovf);
    checks++;
    if (y !== ey || c !== ec || ovf !== eovf) begin
      errors++;
      $display("FAIL %s: got y=%h c=%b ovf=%b, expected y=%h c=%b ovf=%b",
               name, y, c, ovf, ey, ec, eovf);
    end
  endtask

  task automatic drive(input logic [2:0] fn, input logic [31:0] ra, input logic [31:0] rb);
    @(negedge clk);
    f = fn; a = ra; b = rb;
  endtask

  task automatic apply_model(input string name, input logic [2:0] fn,
                             input logic [31:0] ra, input logic [31:0] rb);
    logic [31:0] ey; logic ec, eovf;
    model(fn, ra, rb, ey, ec, eovf);
    drive(fn, ra, rb);
    @(posedge clk); #1;
    compare(name, ey, ec, eovf);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] ey, ra, rb;
    logic ec, eovf;
    logic [2:0] fn;

    vecs.push_back('{"add_wrap",   F_ADD,    32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{"add_ovf",    F_ADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1});
    vecs.push_back('{"sub_5_3",    F_SUB,    32'd5,        32'd3,        32'd2,        1'b1, 1'b0});
    vecs.push_back('{"sub_3_5",    F_SUB,    32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0});
    vecs.push_back('{"sub_ovf",    F_SUB,    32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1});
    vecs.push_back('{"slt_neg",    F_SLT,    32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b0});
    vecs.push_back('{"slt_pos",    F_SLT,    32'h00000001, 32'h80000000, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{"slt_eq",     F_SLT,    32'd7,        32'd7,        32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{"and",        F_AND,    32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0});
    vecs.push_back('{"or",         F_OR,     32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0});
    vecs.push_back('{"and_n",      F_AND_N,  32'hF0F0F0F0, 32'hFF00FF00, 32'h00F000F0, 1'b0, 1'b0});
    vecs.push_back('{"or_n",       F_OR_N,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF0FFF0FF, 1'b0, 1'b0});
    vecs.push_back('{"unused",     F_UNUSED, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{"unused_add", F_UNUSED, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0});

    rstn = 1'b0; a = '0; b = '0; f = '0;
    #3;
    compare("reset_state", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].fn, vecs[i].a, vecs[i].b);
      @(posedge clk); #1;
      compare(vecs[i].name, vecs[i].y, vecs[i].c, vecs[i].ovf);
    end

    // Outputs hold between edges even though inputs have changed.
    apply_model("pre_hold", F_ADD, 32'h12345678, 32'h11111111);
    drive(F_AND, 32'h0, 32'h0);
    #1;
    compare("hold_between_edges", 32'h23456789, 1'b0, 1'b0);

    for (int i = 0; i < 100; i++) begin
      fn = 3'(i % 8);
      ra = $urandom;
      rb = $urandom;
      if (i % 16 == 7) rb = ra;
      if (i == 50) begin
        // Reset during an operation: prior result nonzero, pending one discarded.
        apply_model("pre_reset", F_OR, 32'hA5A5A5A5, 32'h0000FFFF);
        drive(F_OR_N, 32'h0, 32'h0);
        #2 rstn = 1'b0;
        #1 compare("reset_async", 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        compare("reset_discard", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
      end
      apply_model($sformatf("rand_%0d", i), fn, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion before 200000");
    $fatal(1);
  end

endmodule
